// File: rtl/dist_display.sv
// dist_display: captures a free-running binary distance (cm), converts it to
// four BCD digits with a sequential double-dabble, and multiplexes the result
// onto a 4-digit common-anode 7-segment display.
//
// Ports
//   clock     system clock, all state on the rising edge
//   reset     asynchronous, active-high
//   distance  binary distance in cm, no strobe; changes are detected in IDLE
//   bcd       last converted value, [3:0] = units
//   updated   one-cycle pulse when bcd takes a new value
//   overflow  last captured distance exceeded 9999 (display shows 9999)
//   seg       active-low segments {g,f,e,d,c,b,a}
//   dp        active-low decimal point (lit on the units digit on overflow)
//   an        active-low digit enables, an[0] = units
//
// Conversion FSM
//   state  | meaning
//   IDLE   | waiting for distance to differ from the captured value
//   CONV   | 14 add-3-then-shift steps, one per cycle
//   DONE   | publish bcd/overflow, pulse updated, return to IDLE
module dist_display #(
  parameter int unsigned DIGIT_CYCLES  = 50000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [32:0] distance,
  output logic [15:0] bcd,
  output logic        updated,
  output logic        overflow,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int            PW         = $clog2(DIGIT_CYCLES);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIGIT_CYCLES - 1);
  localparam logic [32:0]   DIST_MAX   = 33'd9999;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [32:0]   dist_q, dist_d;
  logic [13:0]   bin_q, bin_d;
  logic [15:0]   sh_q, sh_d;
  logic [3:0]    step_q, step_d;
  logic          ovf_pend_q, ovf_pend_d;
  logic [15:0]   bcd_q, bcd_d;
  logic          overflow_q, overflow_d;
  logic          updated_q, updated_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    digit_q, digit_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          dp_q, dp_d;

  logic          start;
  logic          over_in;
  logic [13:0]   clamp_in;
  logic [3:0]    nib;
  logic [3:0]    blank;

  // One double-dabble step: correct every digit >= 5, then shift bin into bcd.
  function automatic logic [29:0] dd_step(input logic [15:0] b, input logic [13:0] v);
    logic [15:0] adj;
    for (int i = 0; i < 4; i++) begin
      adj[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
    end
    return {adj, v} << 1;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  assign start    = (state_q == S_IDLE) && (distance != dist_q);
  assign over_in  = distance > DIST_MAX;
  assign clamp_in = over_in ? 14'd9999 : distance[13:0];

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CONV;
      S_CONV:  if (step_q == 4'd0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs / conversion datapath
  always_comb begin
    dist_d     = dist_q;
    bin_d      = bin_q;
    sh_d       = sh_q;
    step_d     = step_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    updated_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dist_d     = distance;
          bin_d      = clamp_in;
          sh_d       = '0;
          ovf_pend_d = over_in;
          step_d     = 4'd13;
        end
      end
      S_CONV: begin
        {sh_d, bin_d} = dd_step(sh_q, bin_q);
        step_d        = step_q - 4'd1;
      end
      S_DONE: begin
        bcd_d      = sh_q;
        overflow_d = ovf_pend_q;
        updated_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // Display scan: outputs are only reloaded at the prescaler wrap, so a slot
  // always shows the bcd value that was current when it began.
  always_comb begin
    presc_d = presc_q + 1'b1;
    digit_d = digit_q;
    seg_d   = seg_q;
    an_d    = an_q;
    dp_d    = dp_q;
    nib     = bcd_q[{digit_q, 2'b00} +: 4];
    blank   = 4'b0000;
    if (BLANK_LEADING) begin
      blank[3] = (bcd_q[15:12] == 4'd0);
      blank[2] = blank[3] && (bcd_q[11:8] == 4'd0);
      blank[1] = blank[2] && (bcd_q[7:4] == 4'd0);
    end
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      digit_d = digit_q + 2'd1;
      if (blank[digit_q]) begin
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
      end else begin
        an_d  = ~(4'b0001 << digit_q);
        seg_d = seg_of(nib);
      end
      dp_d = !((digit_q == 2'd0) && overflow_q);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dist_q     <= '0;
      bin_q      <= '0;
      sh_q       <= '0;
      step_q     <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      updated_q  <= 1'b0;
      presc_q    <= '0;
      digit_q    <= '0;
      seg_q      <= 7'b1111111;
      an_q       <= 4'b1111;
      dp_q       <= 1'b1;
    end else begin
      dist_q     <= dist_d;
      bin_q      <= bin_d;
      sh_q       <= sh_d;
      step_q     <= step_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
      updated_q  <= updated_d;
      presc_q    <= presc_d;
      digit_q    <= digit_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      dp_q       <= dp_d;
    end
  end

  assign bcd      = bcd_q;
  assign updated  = updated_q;
  assign overflow = overflow_q;
  assign seg      = seg_q;
  assign an       = an_q;
  assign dp       = dp_q;

endmodule

// File: tb/tb_dist_display.sv
`timescale 1ns/1ps
module tb_dist_display;

  localparam int DC = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [32:0] distance;
  logic [15:0] bcd;
  logic        updated;
  logic        overflow;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  always #5 clock = ~clock;

  dist_display #(.DIGIT_CYCLES(DC), .BLANK_LEADING(1'b1)) dut (
    .clock    (clock),
    .reset    (reset),
    .distance (distance),
    .bcd      (bcd),
    .updated  (updated),
    .overflow (overflow),
    .seg      (seg),
    .dp       (dp),
    .an       (an)
  );

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   pulses   = 0;

  always @(posedge clock) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [6:0] seg_ref(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Monitor: every updated pulse consumes one scoreboard entry.
  always @(negedge clock) begin
    if (!reset && updated === 1'b1) begin
      pulses++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_update: bcd=%h overflow=%b with nothing expected (cycle %0d)",
                 bcd, overflow, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("upd_bcd", 32'(bcd), 32'(e.bcd));
        check("upd_overflow", 32'(overflow), 32'(e.ovf));
        check("upd_latency_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic push_exp(input logic [15:0] b, input logic o, input int due);
    exp_t e;
    e.bcd = b;
    e.ovf = o;
    e.due = due;
    sb_q.push_back(e);
  endtask

  // Drive a new distance at a falling edge; capture happens at the next rising
  // edge and the pulse is seen 15 edges after that.
  task automatic issue(input logic [32:0] d, input logic [15:0] b, input logic o);
    @(negedge clock);
    distance = d;
    push_exp(b, o, cyc + 16);
  endtask

  task automatic finish_scn(input string name, input int p0, input int n_exp);
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 100) begin
      @(negedge clock);
      t++;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_timeout: %0d updates still outstanding", name, sb_q.size());
      sb_q.delete();
    end
    repeat (20) @(negedge clock);
    check({name, "_pulses"}, 32'(pulses - p0), 32'(n_exp));
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_bcd"}, 32'(bcd), 32'h0);
    check({name, "_updated"}, 32'(updated), 32'h0);
    check({name, "_overflow"}, 32'(overflow), 32'h0);
    check({name, "_seg"}, 32'(seg), 32'h7F);
    check({name, "_an"}, 32'(an), 32'hF);
    check({name, "_dp"}, 32'(dp), 32'h1);
  endtask

  // Observe 16 consecutive cycles (one full scan) and check every sample.
  task automatic check_display(input string name, input logic [15:0] val,
                               input logic ovf, input logic [3:0] blank);
    int          cnt[4];
    int          nb;
    int          nblank;
    int          idx;
    logic [3:0]  oh;
    logic [15:0] v;
    v   = val;
    cnt = '{0, 0, 0, 0};
    nb  = 0;
    nblank = 0;
    repeat (8) @(negedge clock);
    for (int s = 0; s < 16; s++) begin
      @(negedge clock);
      if (an == 4'b1111) begin
        nb++;
        check({name, "_blank_seg"}, 32'(seg), 32'h7F);
        check({name, "_blank_dp"}, 32'(dp), 32'h1);
      end else begin
        idx = -1;
        for (int i = 0; i < 4; i++) begin
          oh = 4'b0001 << i;
          if (an == ~oh) idx = i;
        end
        if (idx < 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL %s_an_pattern: got %b expected one active-low digit", name, an);
        end else begin
          check({name, "_seg"}, 32'(seg), 32'(seg_ref(v[4*idx +: 4])));
          check({name, "_dp"}, 32'(dp), (idx == 0 && ovf) ? 32'h0 : 32'h1);
          cnt[idx]++;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      check({name, "_slot_count"}, 32'(cnt[i]), blank[i] ? 32'd0 : 32'd4);
      if (blank[i]) nblank++;
    end
    check({name, "_blank_count"}, 32'(nb), 32'(4 * nblank));
  endtask

  initial begin
    int t;
    int t0;
    int p0;
    int k;

    reset    = 1'b1;
    distance = '0;
    repeat (3) @(negedge clock);
    check_reset_vals("por");

    // First slot after release: digit 0 showing "0" at the first wrap.
    @(negedge clock);
    reset = 1'b0;
    t0 = cyc;
    t  = 0;
    while (an === 4'b1111 && t < 20) begin
      @(negedge clock);
      t++;
    end
    check("first_slot_an", 32'(an), 32'hE);
    check("first_slot_seg", 32'(seg), 32'h40);
    check("first_slot_time", 32'(cyc - t0), 32'(DC));

    p0 = pulses;
    issue(33'd1234, 16'h1234, 1'b0);
    finish_scn("conv_1234", p0, 1);
    check_display("disp_1234", 16'h1234, 1'b0, 4'b0000);

    p0 = pulses;
    issue(33'd10000, 16'h9999, 1'b1);
    finish_scn("conv_10000", p0, 1);
    check_display("disp_ovf", 16'h9999, 1'b1, 4'b0000);

    p0 = pulses;
    issue(33'd7, 16'h0007, 1'b0);
    finish_scn("conv_7", p0, 1);
    check_display("disp_7", 16'h0007, 1'b0, 4'b1110);

    // Change during CONV is picked up by a second conversion.
    p0 = pulses;
    @(negedge clock);
    distance = 33'd50;
    k = cyc;
    push_exp(16'h0050, 1'b0, k + 16);
    push_exp(16'h0051, 1'b0, k + 32);
    repeat (3) @(negedge clock);
    distance = 33'd51;
    finish_scn("conv_50_51", p0, 2);

    // Excursion that returns to the captured value triggers nothing extra.
    p0 = pulses;
    issue(33'd555, 16'h0555, 1'b0);
    repeat (3) @(negedge clock);
    distance = 33'd556;
    repeat (3) @(negedge clock);
    distance = 33'd555;
    finish_scn("conv_555_return", p0, 1);

    p0 = pulses;
    issue(33'd99, 16'h0099, 1'b0);
    repeat (1000) @(negedge clock);
    finish_scn("hold_99", p0, 1);

    p0 = pulses;
    issue(33'd9999, 16'h9999, 1'b0);
    finish_scn("conv_9999", p0, 1);

    p0 = pulses;
    issue(33'h1_0000_0000, 16'h9999, 1'b1);
    finish_scn("conv_wide", p0, 1);

    p0 = pulses;
    issue(33'd0, 16'h0000, 1'b0);
    finish_scn("conv_0", p0, 1);
    check_display("disp_0", 16'h0000, 1'b0, 4'b1110);

    // Reset in the middle of a conversion aborts it; the value reconverts.
    p0 = pulses;
    @(negedge clock);
    distance = 33'd4321;
    repeat (7) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_reset_vals("mid_reset");
    check("mid_reset_no_pulse", 32'(pulses - p0), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    push_exp(16'h4321, 1'b0, cyc + 16);
    finish_scn("conv_4321_after_reset", p0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dist_display.md
DIST_DISPLAY -- requirements
Module: dist_display

Interface
REQ-001 Parameter DIGIT_CYCLES, default 50000, meaning clocks per digit scan slot (1 ms at 50 MHz); legal range 2..2^20.
REQ-002 Parameter BLANK_LEADING, default 1, meaning 1 blanks leading-zero digits and 0 shows all four digits.
REQ-003 clock  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 distance  input  33  binary distance in cm from the ranging stage; may change on any clock edge; has no strobe.
REQ-006 bcd  output  16  last converted value, four BCD digits, [3:0] = units.
REQ-007 updated  output  1  one-cycle pulse when bcd takes a new value.
REQ-008 overflow  output  1  high while the last captured distance exceeded 9999.
REQ-009 seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-010 dp  output  1  active-low decimal point.
REQ-011 an  output  4  active-low digit enables, an[0] = units (rightmost).

Function
REQ-012 Registers dist_q (33 b); when the FSM is IDLE and distance != dist_q, load dist_q <= distance and enter CONV on the next edge.
REQ-013 Clamp: if the captured value is > 9999, the converter input is 9999 and overflow is set at the update; otherwise the input is the value and overflow is cleared at the update.
REQ-014 Conversion uses sequential double-dabble on 14 bits: CONV performs one add-3-then-shift per cycle for exactly 14 cycles, then enters DONE.
REQ-015 The FSM states are IDLE -> CONV (14 cycles) -> DONE (1 cycle) -> IDLE; no other transitions exist except reset.
REQ-016 In DONE, bcd and overflow are written and updated = 1 for that single cycle.
REQ-017 Latency: capture at edge N, bcd/updated visible after edge N+15; back-to-back conversions start no sooner than one cycle after DONE.
REQ-018 A change of distance during CONV/DONE is ignored for the current conversion; it is detected in IDLE against dist_q, so the final settled value is always converted.
REQ-019 A distance returning to the value already in dist_q triggers no conversion.
REQ-020 Scan: a prescaler counts 0..DIGIT_CYCLES-1; at wrap, digit index advances 0->1->2->3->0.
REQ-021 For the active digit i, an = ~(1<<i) and seg = the active-low pattern of bcd[4i+3:4i] (0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000); codes 10-15 give 1111111.
REQ-022 Blanking (BLANK_LEADING=1): digit i>0 is blanked when it and all higher digits are zero; digit 0 is never blanked; a blanked slot drives an = 1111 and seg = 1111111.
REQ-023 dp = 0 only during the digit-0 slot while overflow = 1; dp = 1 otherwise.
REQ-024 seg, an and dp are registered; they change only on prescaler wrap or reset release, never mid-slot, and the display uses the bcd value current at the slot start.

Reset
REQ-025 While reset is high: dist_q = 0, FSM = IDLE, bcd = 0, updated = 0, overflow = 0, prescaler = 0, digit index = 0, seg = 1111111, an = 1111, dp = 1.
REQ-026 Reset asserted mid-conversion aborts it with no updated pulse; after release, a distance != 0 starts a fresh conversion from IDLE.
REQ-027 The first digit slot (digit 0, showing "0") is driven at the first prescaler wrap after reset release.

Verification
REQ-028 distance 0 -> 1234 after reset -> updated pulse exactly 15 cycles after capture, bcd = 16'h1234, overflow = 0.
REQ-029 distance = 10000 -> bcd = 16'h9999, overflow = 1, dp = 0 only in the an = 1110 slot.
REQ-030 distance = 7, BLANK_LEADING=1, DIGIT_CYCLES=4 -> over 16 cycles an sequence 1110,1111,1111,1111; seg = 1111000 in slot 0.
REQ-031 distance 50 -> 51 at capture+3 -> first updated gives bcd=16'h0050, a second updated ~16 cycles later gives 16'h0051; exactly two pulses.
REQ-032 reset pulsed at capture+7 of a conversion of 4321 -> no updated pulse, all outputs at reset values; after release, conversion of 4321 completes with bcd = 16'h4321.
REQ-033 distance held at 99 for 1000 cycles -> exactly one updated pulse.
